// File: rtl/demux_1_2_reg.sv
// Registered 1-to-2 demultiplexer with per-output valid/ready holding slots.
// An accepted word is steered by sel into slot 0 or slot 1. The slot then
// presents the word until its consumer takes it.
// Optional build macro DEMUX_1_2_CNT_EN adds the saturating per-output
// accept counters cnt0 and cnt1.
module demux_1_2_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [0:WIDTH-1] a,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [0:WIDTH-1] y0,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [0:WIDTH-1] y1
`ifdef DEMUX_1_2_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            r_state0, r_state1;
  slot_t            w_next0,  w_next1;
  logic [0:WIDTH-1] r_y0, r_y1;
  logic             w_free0, w_free1;
  logic             w_acc0,  w_acc1;

  // A slot can take a word when it is empty or is being drained this cycle.
  // The ready path depends only on enb, sel and the targeted slot.
  always_comb begin
    w_free0  = (r_state0 == EMPTY) | y0_ready;
    w_free1  = (r_state1 == EMPTY) | y1_ready;
    in_ready = enb & (sel ? w_free1 : w_free0);
    w_acc0   = in_valid & in_ready & ~sel;
    w_acc1   = in_valid & in_ready &  sel;
  end

  // Slot state registers; reset empties both slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state0 <= EMPTY;
      r_state1 <= EMPTY;
    end else begin
      r_state0 <= w_next0;
      r_state1 <= w_next1;
    end
  end

  // Next state: an accept wins over a drain, so a slot that is drained and
  // reloaded in the same cycle stays FULL.
  always_comb begin
    w_next0 = r_state0;
    w_next1 = r_state1;
    if (w_acc0)
      w_next0 = FULL;
    else if ((r_state0 == FULL) && y0_ready)
      w_next0 = EMPTY;
    if (w_acc1)
      w_next1 = FULL;
    else if ((r_state1 == FULL) && y1_ready)
      w_next1 = EMPTY;
  end

  // Output decode: valid mirrors the slot state, and data comes straight
  // from the holding registers.
  always_comb begin
    y0_valid = (r_state0 == FULL);
    y1_valid = (r_state1 == FULL);
    y0       = r_y0;
    y1       = r_y1;
  end

  // Data holding registers load only on an accept and otherwise keep their
  // last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y0 <= '0;
      r_y1 <= '0;
    end else begin
      if (w_acc0) r_y0 <= a;
      if (w_acc1) r_y1 <= a;
    end
  end

`ifdef DEMUX_1_2_CNT_EN
  logic [15:0] r_cnt0, r_cnt1;

  // Saturating accept counters, one for each destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_acc1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_1_2_reg.sv
// Self-checking bench for demux_1_2_reg. A reference model tracks the slot
// occupancy and the expected in_ready. Accepted words are pushed into
// per-output queues and compared in order as each output presents or
// drains its word.
module tb_demux_1_2_reg;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, enb, in_valid, sel, y0_ready, y1_ready;
  logic         in_ready, y0_valid, y1_valid;
  logic [0:W-1] a, y0, y1;
`ifdef DEMUX_1_2_CNT_EN
  logic [15:0]  cnt0, cnt1;
`endif

  demux_1_2_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a),
    .y0_valid(y0_valid), .y0_ready(y0_ready), .y0(y0),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1(y1)
`ifdef DEMUX_1_2_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [W-1:0] q0[$], q1[$];
  logic         m_v0 = 1'b0, m_v1 = 1'b0;
  logic [15:0]  m_c0 = '0, m_c1 = '0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Check one cycle against the model, advance the model, then step past the edge.
  task automatic cycle();
    logic er, d0, d1, acc, was_rst;
    #2;
    er = enb & (sel ? (!m_v1 | y1_ready) : (!m_v0 | y0_ready));
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    chk("y0_valid", {31'd0, y0_valid}, {31'd0, m_v0});
    chk("y1_valid", {31'd0, y1_valid}, {31'd0, m_v1});
    if (m_v0) begin
      if (q0.size() > 0) chk("y0_data", y0, q0[0]);
      else chk("q0_underflow", 32'd1, 32'd0);
    end
    if (m_v1) begin
      if (q1.size() > 0) chk("y1_data", y1, q1[0]);
      else chk("q1_underflow", 32'd1, 32'd0);
    end
    was_rst = rst;
    if (rst) begin
      m_v0 = 1'b0; m_v1 = 1'b0; q0.delete(); q1.delete();
      m_c0 = '0; m_c1 = '0;
    end else begin
      d0  = m_v0 & y0_ready;
      d1  = m_v1 & y1_ready;
      acc = in_valid & er;
      if (d0) void'(q0.pop_front());
      if (d1) void'(q1.pop_front());
      if (acc && !sel) begin
        q0.push_back(a); m_v0 = 1'b1;
        if (m_c0 != 16'hFFFF) m_c0 = m_c0 + 16'd1;
      end else if (d0) m_v0 = 1'b0;
      if (acc && sel) begin
        q1.push_back(a); m_v1 = 1'b1;
        if (m_c1 != 16'hFFFF) m_c1 = m_c1 + 16'd1;
      end else if (d1) m_v1 = 1'b0;
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      chk("rst_y0", y0, 32'd0);
      chk("rst_y1", y1, 32'd0);
    end
`ifdef DEMUX_1_2_CNT_EN
    chk("cnt0", {16'd0, cnt0}, {16'd0, m_c0});
    chk("cnt1", {16'd0, cnt1}, {16'd0, m_c1});
`endif
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; in_valid = 1'b1; sel = 1'b0; a = 32'hDEADBEEF;
    y0_ready = 1'b0; y1_ready = 1'b0;
    // First edge brings the DUT out of X; every later cycle is checked.
    @(posedge clk); #1;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) cycle();

    // Basic steering to each output.
    a = 32'h00010101; sel = 1'b0; in_valid = 1'b1; cycle();
    in_valid = 1'b0; cycle();
    chk("steer_y0", y0, 32'h00010101);
    a = 32'h00020202; sel = 1'b1; in_valid = 1'b1; cycle();
    in_valid = 1'b0; cycle();
    chk("steer_y1", y1, 32'h00020202);
    chk("steer_y0_hold", y0, 32'h00010101);

    // Backpressure on a full slot 0, then release it.
    a = 32'h0000AAAA; sel = 1'b0; in_valid = 1'b1;
    repeat (5) cycle();
    y0_ready = 1'b1; cycle();
    in_valid = 1'b0; y0_ready = 1'b0; cycle();
    chk("bp_y0", y0, 32'h0000AAAA);

    // Stream eight words into output 0 while its consumer stays ready.
    y0_ready = 1'b1; sel = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a = i; in_valid = 1'b1; cycle();
      chk("stream_y0", y0, i);
    end
    in_valid = 1'b0; repeat (2) cycle();

    // With enb low nothing is accepted, but full slot 1 still drains.
    enb = 1'b0; in_valid = 1'b1; sel = 1'b1; a = 32'h0000BBBB; y1_ready = 1'b1;
    cycle();
    y1_ready = 1'b0; sel = 1'b0; repeat (2) cycle();
    enb = 1'b1;

    // Reset while slot 0 is full and an accept is pending.
    y0_ready = 1'b0; sel = 1'b0; a = 32'h00001234; in_valid = 1'b1; cycle();
    a = 32'h00005678; rst = 1'b1; cycle();
    rst = 1'b0; in_valid = 1'b0; cycle();

`ifdef DEMUX_1_2_CNT_EN
    // Counter scenario: three accepts to output 0 and two to output 1.
    y0_ready = 1'b1; y1_ready = 1'b1; in_valid = 1'b1;
    sel = 1'b0; repeat (3) cycle();
    sel = 1'b1; repeat (2) cycle();
    in_valid = 1'b0; cycle();
    chk("cnt0_is3", {16'd0, cnt0}, 32'd3);
    chk("cnt1_is2", {16'd0, cnt1}, 32'd2);
    // Drive cnt0 to saturation, then accept once more.
    sel = 1'b0; in_valid = 1'b1;
    repeat (65532) cycle();
    chk("cnt0_max", {16'd0, cnt0}, 32'h0000FFFF);
    cycle();
    chk("cnt0_sat", {16'd0, cnt0}, 32'h0000FFFF);
    in_valid = 1'b0; cycle();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      enb = ($urandom_range(0, 7) != 0);
      in_valid = $urandom_range(0, 1);
      sel = $urandom_range(0, 1);
      a = $urandom;
      y0_ready = $urandom_range(0, 1);
      y1_ready = $urandom_range(0, 1);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_1_2_reg.md
Name: demux_1_2_reg

Overview:
- Registered 1-to-2 demultiplexer: the steering counterpart of the 2:1 mux.
- Accepts one WIDTH-bit word per cycle on a valid/ready input and routes it by `sel` into one of two output holding registers.
- Each output register presents the word on its own valid/ready port until the word is consumed.
- Used where a datapath result is distributed to one of two downstream consumers, e.g. the register-file write port vs. the memory store path.

Parameters:
- WIDTH, 32, data word width; all data buses are [0:WIDTH-1], bit 0 is the MSB.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  accept enable; when 0 no new word is accepted, and stored words still drain.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block accepts the word this cycle.
- sel  in  1  destination select, sampled with the word: 0 → output 0, 1 → output 1.
- a  in  WIDTH  input data word.
- y0_valid  out  1  output 0 holds a word.
- y0_ready  in  1  consumer 0 takes the word this cycle.
- y0  out  WIDTH  output 0 data.
- y1_valid  out  1  output 1 holds a word.
- y1_ready  in  1  consumer 1 takes the word this cycle.
- y1  out  WIDTH  output 1 data.

Behaviour:
- **Reset:** one clock, one reset. Reset is synchronous and active-high. While rst=1 at a rising edge:
  - y0_valid=0, y1_valid=0, y0=0, y1=0.
  - rst overrides any transfer in the same cycle. A word offered in that cycle is dropped, and a held word is discarded.
- **Slot state:** each output slot k is a 2-state FSM, EMPTY (yk_valid=0) or FULL (yk_valid=1).
- **in_ready** is combinational: in_ready = enb & (sel ? free1 : free0), where freek = ~yk_valid | yk_ready.
  - in_ready depends on sel, enb and the target slot only. It does not depend on in_valid.
- **Accept:** acc = in_valid & in_ready.
  - On acc, the target slot k=sel loads yk <= a and becomes FULL at the next edge.
  - Latency: 1 cycle from accept to yk_valid.
- **Drain:** when yk_valid & yk_ready and no accept targets slot k, slot k goes to EMPTY.
  - yk keeps its last value when EMPTY; data is don't-care when valid=0 but is not cleared.
- **Simultaneous drain and accept on the same slot:** the slot stays FULL with the new word. This gives full throughput of 1 word/cycle into a single output while its consumer is ready.
- **Non-target slot:** it drains independently in the same cycle an accept targets the other slot.
- **FULL and not ready:** in_ready=0 for words targeting that slot, so no head-of-line reordering occurs. The upstream must hold a, sel and in_valid stable until accepted.
- **No reordering within an output:** words reach each output in acceptance order.
- **Valid hold:** yk_valid, once set, never drops without yk_ready=1 or rst=1.
- **enb=0:** in_ready=0 and no word is accepted. Slot FSMs continue to drain normally.
- **Transfer rule:** no combinational path from a to y0/y1; outputs are registered. A word is transferred exactly once, and only on an accept.

Optional Feature:
- Macro DEMUX_1_2_CNT_EN.
- **When defined**, two output ports are added:
  - cnt0 out 16: count of words accepted toward output 0.
  - cnt1 out 16: count of words accepted toward output 1.
  - Each counter increments on acc with matching sel and saturates at 16'hFFFF, with no wrap.
  - Both counters reset to 0 on rst.
- **When not defined**, the ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- **Reset:** rst=1 for 2 cycles with in_valid=1 → y0_valid=y1_valid=0, y0=y1=0; no word appears after rst drops until a new accept.
- **Basic steering:**
  - enb=1, a=32'h00010101, sel=0, in_valid=1 for 1 cycle, y0_ready=0 → next cycle y0_valid=1, y0=32'h00010101, y1_valid=0.
  - Then a=32'h00020202, sel=1 → y1=32'h00020202, y1_valid=1; y0 holds unchanged.
- **Backpressure:**
  - Slot 0 FULL, y0_ready=0, in_valid=1, sel=0, a=32'h0000AAAA → in_ready=0 for 5 cycles; y0 unchanged.
  - Raise y0_ready → accept in that cycle; y0=32'h0000AAAA next cycle.
- **Streaming:** y0_ready=1, sel=0, 8 back-to-back words 1..8 → in_ready=1 every cycle; y0 shows 1..8 on consecutive cycles, starting 1 cycle after the first accept.
- **Enable and mid-operation reset:**
  - enb=0 with in_valid=1 → in_ready=0, nothing loaded, while a full slot 1 still drains when y1_ready=1.
  - rst=1 asserted while slot 0 FULL and an accept is pending → both slots EMPTY next cycle.
- **Counters (DEMUX_1_2_CNT_EN):** 3 accepts to output 0 and 2 to output 1 → cnt0=3, cnt1=2. Force cnt0=16'hFFFF, then 1 more accept → cnt0 stays 16'hFFFF.
